lock_servo_driver: RTL
======================

// Module: lock_servo_driver
// PURPOSE
//  Downstream actuator stage for the UART lock controller: consumes the level command lock_open and drives a hobby servo.
//  Emits a fixed-period PWM frame and ramps the pulse width between closed and open positions at a bounded rate per frame.
//  Reports motion and end-position status for LEDs and for an optional status reporter.
// PARAMETERS
//  PWM_PERIOD_CLKS   1_000_000  frame length in clk cycles (20 ms @ 50 MHz)
//  PULSE_CLOSED_CLKS 50_000     high time at closed position (1.0 ms)
//  PULSE_OPEN_CLKS   100_000    high time at open position (2.0 ms)
//  STEP_CLKS         500        max pulse-width change per frame (full travel = 100 frames = 2 s)
//  Legal: 0 < PULSE_CLOSED_CLKS < PULSE_OPEN_CLKS < PWM_PERIOD_CLKS, STEP_CLKS >= 1; violation -> elaboration error.
// PORTS
//  clk        in   1  system clock, 50 MHz
//  rst        in   1  asynchronous reset, active-low
//  lock_open  in   1  command level, synchronous to clk: 1 = open, 0 = closed
//  servo_pwm  out  1  servo control pulse, registered
//  moving     out  1  1 while state is OPENING or CLOSING
//  at_open    out  1  1 in state OPEN
//  at_closed  out  1  1 in state CLOSED
// BEHAVIOUR
//  Reset (rst=0, async): frame_cnt=0, pulse_w=PULSE_CLOSED_CLKS, state=CLOSED, servo_pwm=0, moving=0, at_open=0, at_closed=1.
//  frame_cnt: 0..PWM_PERIOD_CLKS-1, +1 per clk, wraps to 0. Width = $clog2(PWM_PERIOD_CLKS); pulse_w has the same width.
//  Frame boundary (FB) = cycle with frame_cnt==PWM_PERIOD_CLKS-1. pulse_w, state and the lock_open sample change only at FB.
//  servo_pwm <= (frame_cnt < pulse_w): exactly pulse_w consecutive high clocks per frame, starting 1 clk after frame_cnt==0.
//  pulse_w never changes mid-frame -> no runt or stretched pulses.
//  FSM, evaluated at FB with cmd = lock_open sampled at FB:
//   CLOSED : cmd=1 -> OPENING, pulse_w += step (clamped)
//   OPENING: cmd=0 -> CLOSING, pulse_w -= step (clamped); cmd=1 -> pulse_w += step, OPEN when new pulse_w==OPEN pos
//   OPEN   : cmd=0 -> CLOSING, pulse_w -= step (clamped)
//   CLOSING: cmd=1 -> OPENING, pulse_w += step (clamped); cmd=0 -> pulse_w -= step, CLOSED when new pulse_w==CLOSED pos
//  Clamp: pulse_w never passes its target; a last partial step lands exactly on the target.
//   Clamp compare is done without wrap (compare remaining distance against STEP_CLKS, not pulse_w+STEP_CLKS).
//  Reversal mid-ramp continues from the current pulse_w; no jump to an end position.
//  lock_open changes between FBs are ignored; only the level at FB counts (glitch-free by construction).
//  Status outputs are registered and update on the same edge as state.
//   at_open and at_closed are never both 1; moving=1 excludes both.
//  Reset mid-ramp: servo_pwm drops to 0 immediately (async).
//   After release, the first frame begins at frame_cnt=0 with the closed-position pulse.
// STRUCTURE
//  lock_defs.vh: state encodings (CLOSED=2'd0, OPENING=2'd1, OPEN=2'd2, CLOSING=2'd3) and the 50 MHz timing defaults.
//   Shared with uart_lock_control.
//  Sub-module servo_pwm_gen: frame counter, FB strobe and registered comparator (inputs pulse_w; outputs fb, pwm).
//   The top level holds the FSM, the pulse_w ramp/clamp and the status registers.
// TESTING  (bench params: PERIOD=100, CLOSED=10, OPEN=30, STEP=5)
//  1 Release rst, lock_open=0 for 5 frames -> servo_pwm high exactly 10 clks per 100, at_closed=1, moving=0.
//  2 lock_open=1 -> widths 15,20,25,30 in the following frames; moving=1 during the ramp.
//    at_open=1 and moving=0 from the FB that sets 30; 30 is held thereafter.
//  3 Open until width=20, then lock_open=0 -> widths 15,10; at_closed=1 at the FB that sets 10.
//  4 lock_open pulsed high for 20 clks mid-frame, low again before FB -> width stays 10, state stays CLOSED.
//  5 rst asserted at width 25 during the high phase -> servo_pwm=0 within the same cycle.
//    After release: width 10, at_closed=1.
//  6 STEP=7 override, lock_open=1 -> widths 17,24,30 (clamped), then at_open=1; closing gives 23,16,10.

Source files
------------

// File: rtl/lock_servo_driver_pkg.sv
// Shared definitions for the lock servo driver: FSM state encodings and 50 MHz timing defaults.
// The encodings match those used by the UART lock controller.
package lock_servo_driver_pkg;

    typedef enum logic [1:0] {
        ST_CLOSED  = 2'd0,
        ST_OPENING = 2'd1,
        ST_OPEN    = 2'd2,
        ST_CLOSING = 2'd3
    } servo_state_e;

    localparam int DEF_PWM_PERIOD_CLKS   = 1_000_000;
    localparam int DEF_PULSE_CLOSED_CLKS = 50_000;
    localparam int DEF_PULSE_OPEN_CLKS   = 100_000;
    localparam int DEF_STEP_CLKS         = 500;

endpackage

// File: rtl/lock_servo_driver_pwm_gen.sv
// Servo PWM generator: free-running frame counter, frame-boundary strobe and registered
// width comparator. The output goes high one clock after the counter wraps to 0.
module lock_servo_driver_pwm_gen
    import lock_servo_driver_pkg::*;
#(
    parameter int PWM_PERIOD_CLKS = DEF_PWM_PERIOD_CLKS,
    parameter int CNT_W           = $clog2(PWM_PERIOD_CLKS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] pulse_w_i,
    output logic             fb_o,
    output logic             pwm_o
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PWM_PERIOD_CLKS - 1);

    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic             pwm_q, pwm_d;

    assign fb_o = (frame_cnt_q == LAST_CNT);

    always_comb begin
        frame_cnt_d = fb_o ? '0 : frame_cnt_q + 1'b1;
        pwm_d       = (frame_cnt_q < pulse_w_i);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_cnt_q <= '0;
            pwm_q       <= 1'b0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            pwm_q       <= pwm_d;
        end
    end

    assign pwm_o = pwm_q;

endmodule

// File: rtl/lock_servo_driver.sv
// Lock servo driver: ramps the servo pulse width between closed and open positions by at most
// STEP_CLKS per PWM frame, following the lock_open level sampled only at frame boundaries.
module lock_servo_driver
    import lock_servo_driver_pkg::*;
#(
    parameter int PWM_PERIOD_CLKS   = DEF_PWM_PERIOD_CLKS,
    parameter int PULSE_CLOSED_CLKS = DEF_PULSE_CLOSED_CLKS,
    parameter int PULSE_OPEN_CLKS   = DEF_PULSE_OPEN_CLKS,
    parameter int STEP_CLKS         = DEF_STEP_CLKS
) (
    input  logic clk,
    input  logic rst,
    input  logic lock_open,
    output logic servo_pwm,
    output logic moving,
    output logic at_open,
    output logic at_closed
);

    localparam int CNT_W = $clog2(PWM_PERIOD_CLKS);
    localparam int SPAN  = PULSE_OPEN_CLKS - PULSE_CLOSED_CLKS;

    localparam logic [CNT_W-1:0] POS_CLOSED = CNT_W'(PULSE_CLOSED_CLKS);
    localparam logic [CNT_W-1:0] POS_OPEN   = CNT_W'(PULSE_OPEN_CLKS);
    // A step wider than the whole travel behaves exactly like a full-travel step and always fits CNT_W.
    localparam logic [CNT_W-1:0] STEP_W     = CNT_W'((STEP_CLKS > SPAN) ? SPAN : STEP_CLKS);

    if (!(PULSE_CLOSED_CLKS > 0 && PULSE_CLOSED_CLKS < PULSE_OPEN_CLKS &&
          PULSE_OPEN_CLKS < PWM_PERIOD_CLKS && STEP_CLKS >= 1)) begin : g_bad_params
        $error("lock_servo_driver: illegal timing parameters");
    end

    // Distance to the target is compared against the step, so the sum never has to fit CNT_W.
    function automatic logic [CNT_W-1:0] ramp_up(input logic [CNT_W-1:0] pw);
        return ((POS_OPEN - pw) <= STEP_W) ? POS_OPEN : pw + STEP_W;
    endfunction

    function automatic logic [CNT_W-1:0] ramp_down(input logic [CNT_W-1:0] pw);
        return ((pw - POS_CLOSED) <= STEP_W) ? POS_CLOSED : pw - STEP_W;
    endfunction

    servo_state_e     state_q, state_d;
    logic [CNT_W-1:0] pulse_w_q, pulse_w_d;
    logic             moving_q, moving_d;
    logic             at_open_q, at_open_d;
    logic             at_closed_q, at_closed_d;
    logic             fb;

    lock_servo_driver_pwm_gen #(
        .PWM_PERIOD_CLKS (PWM_PERIOD_CLKS),
        .CNT_W           (CNT_W)
    ) u_pwm_gen (
        .clk       (clk),
        .rst       (rst),
        .pulse_w_i (pulse_w_q),
        .fb_o      (fb),
        .pwm_o     (servo_pwm)
    );

    always_comb begin
        state_d   = state_q;
        pulse_w_d = pulse_w_q;
        if (fb) begin
            unique case (state_q)
                ST_CLOSED: begin
                    if (lock_open) begin
                        state_d   = ST_OPENING;
                        pulse_w_d = ramp_up(pulse_w_q);
                    end
                end
                ST_OPENING, ST_OPEN: begin
                    if (!lock_open) begin
                        state_d   = ST_CLOSING;
                        pulse_w_d = ramp_down(pulse_w_q);
                    end else begin
                        pulse_w_d = ramp_up(pulse_w_q);
                        if (pulse_w_d == POS_OPEN) state_d = ST_OPEN;
                    end
                end
                ST_CLOSING: begin
                    if (lock_open) begin
                        state_d   = ST_OPENING;
                        pulse_w_d = ramp_up(pulse_w_q);
                    end else begin
                        pulse_w_d = ramp_down(pulse_w_q);
                        if (pulse_w_d == POS_CLOSED) state_d = ST_CLOSED;
                    end
                end
                default: state_d = ST_CLOSED;
            endcase
        end
        moving_d    = (state_d == ST_OPENING) || (state_d == ST_CLOSING);
        at_open_d   = (state_d == ST_OPEN);
        at_closed_d = (state_d == ST_CLOSED);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_CLOSED;
            pulse_w_q   <= POS_CLOSED;
            moving_q    <= 1'b0;
            at_open_q   <= 1'b0;
            at_closed_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            pulse_w_q   <= pulse_w_d;
            moving_q    <= moving_d;
            at_open_q   <= at_open_d;
            at_closed_q <= at_closed_d;
        end
    end

    assign moving    = moving_q;
    assign at_open   = at_open_q;
    assign at_closed = at_closed_q;

endmodule
